led_timer_cfg_seq: RTL and testbench

AXI4-Lite master sequencer that programs the LED_Timer register bank (4 × 32-bit slave registers, offsets 0x0–0xC) from a parallel configuration word on a single start pulse. It issues one write per register in ascending address order and, optionally, reads every register back and checks it. It sits between fabric control logic and the LED_Timer S00_AXI port, replacing software or VIP register programming.

---
 rtl/led_timer_cfg_seq.sv | 130 +++++++++++++
 tb/tb_led_timer_cfg_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_timer_cfg_seq.sv
// led_timer_cfg_seq: AXI4-Lite master that writes cfg_data into the LED_Timer register bank on start.
// Define LED_TIMER_CFG_READBACK_EN to read every register back and compare it against what was written.
module led_timer_cfg_seq #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
  parameter int                            C_NUM_REGS         = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            start,
  input  logic [C_NUM_REGS*32-1:0]        cfg_data,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [1:0]                      err_index,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;
  state_t                          r_state, w_next;
  logic [1:0]                      r_idx, r_err_index;
  logic [C_NUM_REGS*32-1:0]        r_shadow;
  logic                            r_aw_done, r_w_done, r_error;
  logic                            w_last, w_aw_ok, w_w_ok;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   w_addr;
  logic [31:0]                     w_word;
  assign w_last  = r_idx == 2'(C_NUM_REGS - 1);
  assign w_addr  = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({r_idx, 2'b00});
  assign w_word  = r_shadow[32*r_idx +: 32];
  // a channel counts as done once its handshake happened, now or in an earlier cycle
  assign w_aw_ok = r_aw_done | M_AXI_AWREADY;
  assign w_w_ok  = r_w_done | M_AXI_WREADY;
`ifndef LED_TIMER_CFG_READBACK_EN
  logic w_unused_rd;
  assign w_unused_rd = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_error     <= 1'b0;
      r_err_index <= '0;
    end else begin
      r_state   <= w_next;
      r_aw_done <= r_state == WR_REQ && w_aw_ok && !w_w_ok;
      r_w_done  <= r_state == WR_REQ && w_w_ok && !w_aw_ok;
      if (r_state == IDLE && start) begin
        r_shadow    <= cfg_data;
        r_idx       <= '0;
        r_error     <= 1'b0;
        r_err_index <= '0;
      end
      if (r_state == WR_RESP && M_AXI_BVALID) begin
        if (M_AXI_BRESP != 2'b00 && !r_error) begin
          r_error     <= 1'b1;
          r_err_index <= r_idx;
        end
        r_idx <= w_last ? 2'd0 : r_idx + 2'd1;
      end
`ifdef LED_TIMER_CFG_READBACK_EN
      if (r_state == RD_RESP && M_AXI_RVALID) begin
        if ((M_AXI_RRESP != 2'b00 || M_AXI_RDATA != w_word) && !r_error) begin
          r_error     <= 1'b1;
          r_err_index <= r_idx;
        end
        r_idx <= w_last ? 2'd0 : r_idx + 2'd1;
      end
`endif
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? WR_REQ : IDLE;
      WR_REQ:  w_next = (w_aw_ok && w_w_ok) ? WR_RESP : WR_REQ;
`ifdef LED_TIMER_CFG_READBACK_EN
      WR_RESP: w_next = !M_AXI_BVALID ? WR_RESP : w_last ? RD_REQ : WR_REQ;
      RD_REQ:  w_next = M_AXI_ARREADY ? RD_RESP : RD_REQ;
      RD_RESP: w_next = !M_AXI_RVALID ? RD_RESP : w_last ? DONE : RD_REQ;
`else
      WR_RESP: w_next = !M_AXI_BVALID ? WR_RESP : w_last ? DONE : WR_REQ;
`endif
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    busy          = r_state != IDLE && r_state != DONE;
    done          = r_state == DONE;
    error         = r_error;
    err_index     = r_err_index;
    M_AXI_AWPROT  = 3'b000;
    M_AXI_ARPROT  = 3'b000;
    M_AXI_WSTRB   = '1;
    M_AXI_AWVALID = r_state == WR_REQ && !r_aw_done;
    M_AXI_WVALID  = r_state == WR_REQ && !r_w_done;
    M_AXI_AWADDR  = r_state == WR_REQ ? w_addr : '0;
    M_AXI_WDATA   = r_state == WR_REQ ? C_M_AXI_DATA_WIDTH'(w_word) : '0;
    M_AXI_BREADY  = r_state == WR_RESP;
`ifdef LED_TIMER_CFG_READBACK_EN
    M_AXI_ARVALID = r_state == RD_REQ;
    M_AXI_ARADDR  = r_state == RD_REQ ? w_addr : '0;
    M_AXI_RREADY  = r_state == RD_RESP;
`else
    M_AXI_ARVALID = 1'b0;
    M_AXI_ARADDR  = '0;
    M_AXI_RREADY  = 1'b0;
`endif
  end
endmodule

// File: tb/tb_led_timer_cfg_seq.sv
// tb_led_timer_cfg_seq: randomized bench for led_timer_cfg_seq against a behavioural AXI4-Lite slave and register model.
module tb_led_timer_cfg_seq;
  localparam int N = 4;
`ifdef LED_TIMER_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [N*32-1:0] cfg_data = '0;
  logic busy, done, error;
  logic [1:0] err_index;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, rvalid, rready;
  logic [1:0] bresp;
  always #5 clk = ~clk;
  led_timer_cfg_seq dut (
    .ACLK(clk), .ARESET(rst), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error), .err_index(err_index),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(1'b1),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(2'b00), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );
  int vectors = 0, miscompares = 0;
  int aw_delay = 0, w_delay = 0, bresp_err_idx = -1;
  logic [3:0] rbad = '0;
  int aw_cnt, w_cnt, cyc;
  bit busy_bad;
  logic got_aw, got_w;
  logic [31:0] aw_lat, w_lat, w_a, w_d;
  logic [31:0] mem [4];
  logic [31:0] wa_q[$], wd_q[$], ra_q[$];
  assign awready = aw_cnt >= aw_delay;
  assign wready  = w_cnt >= w_delay;
  assign w_a = got_aw ? aw_lat : awaddr;
  assign w_d = got_w ? w_lat : wdata;
  // slave: write commits when both AW and W are in, B follows one cycle later; R one cycle after AR
  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; got_aw <= 0; got_w <= 0;
      bvalid <= 0; bresp <= 0; rvalid <= 0; rdata <= 0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (awvalid && awready) begin got_aw <= 1; aw_lat <= awaddr; end
      if (wvalid && wready) begin got_w <= 1; w_lat <= wdata; end
      if ((got_aw || (awvalid && awready)) && (got_w || (wvalid && wready))) begin
        wa_q.push_back(w_a);
        wd_q.push_back(w_d);
        mem[w_a[3:2]] <= w_d;
        bvalid <= 1;
        bresp  <= (int'(w_a[3:2]) == bresp_err_idx) ? 2'b10 : 2'b00;
        got_aw <= 0; got_w <= 0;
      end else if (bvalid && bready) bvalid <= 0;
      if (arvalid) begin
        ra_q.push_back(araddr);
        rvalid <= 1;
        rdata  <= rbad[araddr[3:2]] ? 32'hDEAD : mem[araddr[3:2]];
      end else if (rvalid && rready) rvalid <= 0;
    end
  end
  function automatic int write_errs(logic [N*32-1:0] cfg);
    int n = 0;
    if (wa_q.size() != N || wd_q.size() != N) return 99;
    for (int i = 0; i < N; i++) begin
      if (wa_q[i] !== 32'(4 * i)) n++;
      if (wd_q[i] !== cfg[32*i +: 32]) n++;
    end
    return n;
  endfunction
  function automatic int read_errs();
    int n = 0;
    if (ra_q.size() != (RB ? N : 0)) return 99;
    foreach (ra_q[i]) if (ra_q[i] !== 32'(4 * i)) n++;
    return n;
  endfunction
  // first failure in time: any bad write precedes every read
  function automatic int first_fail(int bidx, logic [3:0] rb);
    if (bidx >= 0 && bidx < N) return bidx;
    if (RB) for (int i = 0; i < N; i++) if (rb[i]) return i;
    return -1;
  endfunction
  function automatic int zero_wait_cycles();
    return RB ? 4 * N + 2 : 2 * N + 2;
  endfunction
  task automatic kick(input logic [N*32-1:0] cfg);
    wa_q.delete(); wd_q.delete(); ra_q.delete();
    busy_bad = 0;
    @(negedge clk);
    cfg_data = cfg;
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 2;
  endtask
  task automatic wait_done(input int poke_cyc, input bit poke_done);
    for (int k = 0; k < 400; k++) begin
      if (done) begin
        if (poke_done) begin start = 1; cfg_data = ~cfg_data; end
        return;
      end
      if (!busy) busy_bad = 1;
      start = (cyc == poke_cyc);
      if (start) cfg_data = ~cfg_data;
      @(negedge clk);
      cyc++;
    end
    vectors++; miscompares++;
    $display("FAIL done_timeout: no done pulse within 400 cycles (cycle %0d)", cyc);
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, error, err_index, awvalid, wvalid, bready, arvalid, rready, awaddr, araddr, wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b idx=%0d awv=%b wv=%b br=%b arv=%b rr=%b awaddr=%h araddr=%h wdata=%h, want all 0",
               busy, done, error, err_index, awvalid, wvalid, bready, arvalid, rready, awaddr, araddr, wdata);
    end
    vectors++;
    if ({awprot, arprot, wstrb} !== {3'b000, 3'b000, 4'hF}) begin
      miscompares++;
      $display("FAIL const_outputs: awprot=%b arprot=%b wstrb=%h, want 000 000 f", awprot, arprot, wstrb);
    end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic test_zero_wait();
    logic [N*32-1:0] cfg = {32'h4, 32'h3, 32'h2, 32'h1};
    kick(cfg);
    wait_done(-1, 0);
    vectors++;
    if (cyc !== zero_wait_cycles()) begin
      miscompares++; $display("FAIL zw_latency: done at cycle %0d, want %0d", cyc, zero_wait_cycles());
    end
    vectors++;
    if (write_errs(cfg) !== 0 || read_errs() !== 0) begin
      miscompares++; $display("FAIL zw_transfers: %0d write / %0d read mismatches, want 0", write_errs(cfg), read_errs());
    end
    vectors++;
    if ({error, busy, busy_bad} !== 3'b000) begin
      miscompares++; $display("FAIL zw_status: error=%b busy_at_done=%b busy_dropped=%b, want 000", error, busy, busy_bad);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++; $display("FAIL zw_done_pulse: done=%b one cycle later, want 0", done);
    end
  endtask
  task automatic test_aw_delay();
    logic [N*32-1:0] cfg = {$urandom(), $urandom(), $urandom(), $urandom()};
    aw_delay = 3;
    kick(cfg);
    vectors++;
    if ({awvalid, wvalid, awaddr, wdata} !== {2'b11, 32'h0, cfg[31:0]}) begin
      miscompares++; $display("FAIL awd_first: awv=%b wv=%b awaddr=%h wdata=%h, want 1 1 0 %h", awvalid, wvalid, awaddr, wdata, cfg[31:0]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); cyc++;
      vectors++;
      if ({awvalid, wvalid, awaddr} !== {2'b10, 32'h0}) begin
        miscompares++; $display("FAIL awd_hold%0d: awv=%b wv=%b awaddr=%h, want 1 0 0", i, awvalid, wvalid, awaddr);
      end
    end
    wait_done(-1, 0);
    vectors++;
    if (cyc !== zero_wait_cycles() + 3 * N) begin
      miscompares++; $display("FAIL awd_latency: done at cycle %0d, want %0d", cyc, zero_wait_cycles() + 3 * N);
    end
    vectors++;
    if (write_errs(cfg) !== 0 || error !== 1'b0) begin
      miscompares++; $display("FAIL awd_result: %0d write mismatches error=%b, want 0 0", write_errs(cfg), error);
    end
    aw_delay = 0;
  endtask
  task automatic test_bresp_err();
    logic [N*32-1:0] cfg = {32'h4, 32'h3, 32'h2, 32'h1};
    bresp_err_idx = 2;
    kick(cfg);
    wait_done(-1, 0);
    vectors++;
    if (write_errs(cfg) !== 0) begin
      miscompares++; $display("FAIL bresp_writes: %0d write mismatches, want 0", write_errs(cfg));
    end
    vectors++;
    if ({error, err_index} !== {1'b1, 2'd2}) begin
      miscompares++; $display("FAIL bresp_error: error=%b err_index=%0d, want 1 2", error, err_index);
    end
    bresp_err_idx = -1;
  endtask
  task automatic test_readback_err();
    logic [N*32-1:0] cfg = {32'h4, 32'h3, 32'h2, 32'h1};
    rbad = 4'b1010;
    kick(cfg);
    wait_done(-1, 0);
    vectors++;
    if (read_errs() !== 0) begin
      miscompares++; $display("FAIL rb_reads: %0d read mismatches, want 0", read_errs());
    end
    vectors++;
    if ({error, err_index} !== (RB ? {1'b1, 2'd1} : 3'b000)) begin
      miscompares++; $display("FAIL rb_error: error=%b err_index=%0d, want %b %0d", error, err_index, RB, RB ? 1 : 0);
    end
    rbad = '0;
  endtask
  task automatic test_start_ignored();
    logic [N*32-1:0] cfg = {$urandom(), $urandom(), $urandom(), $urandom()};
    bresp_err_idx = 0;
    kick(cfg);
    wait_done(5, 1);
    @(negedge clk);
    start = 0;
    vectors++;
    if ({busy, awvalid, done} !== 3'b000) begin
      miscompares++; $display("FAIL ign_restart: busy=%b awv=%b done=%b after start in done cycle, want 000", busy, awvalid, done);
    end
    vectors++;
    if (write_errs(cfg) !== 0 || {error, err_index} !== 3'b100) begin
      miscompares++; $display("FAIL ign_writes: %0d write mismatches error=%b idx=%0d, want 0 1 0", write_errs(cfg), error, err_index);
    end
    bresp_err_idx = -1;
    cfg = {$urandom(), $urandom(), $urandom(), $urandom()};
    kick(cfg);
    vectors++;
    if ({error, busy} !== 2'b01) begin
      miscompares++; $display("FAIL ign_clear: error=%b busy=%b after new start, want 0 1", error, busy);
    end
    wait_done(-1, 0);
    vectors++;
    if (write_errs(cfg) !== 0 || error !== 1'b0) begin
      miscompares++; $display("FAIL ign_rerun: %0d write mismatches error=%b, want 0 0", write_errs(cfg), error);
    end
  endtask
  task automatic test_reset_mid();
    logic [N*32-1:0] cfg = {$urandom(), $urandom(), $urandom(), $urandom()};
    int nb = 0;
    kick(cfg);
    for (int k = 0; k < 50 && nb < 2; k++) begin
      if (bready) nb++;
      if (nb < 2) @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    vectors++;
    if ({busy, done, error, err_index, awvalid, wvalid, bready, arvalid, rready, awaddr, araddr, wdata} !== '0 || nb != 2) begin
      miscompares++; $display("FAIL rstmid_outputs: busy=%b done=%b awv=%b wv=%b br=%b awaddr=%h wdata=%h nb=%0d, want all 0 nb=2",
                              busy, done, awvalid, wvalid, bready, awaddr, wdata, nb);
    end
    rst = 0;
    cfg = {$urandom(), $urandom(), $urandom(), $urandom()};
    kick(cfg);
    wait_done(-1, 0);
    vectors++;
    if (write_errs(cfg) !== 0 || cyc !== zero_wait_cycles()) begin
      miscompares++; $display("FAIL rstmid_rerun: %0d write mismatches, done at %0d, want 0 at %0d", write_errs(cfg), cyc, zero_wait_cycles());
    end
  endtask
  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [N*32-1:0] cfg = {$urandom(), $urandom(), $urandom(), $urandom()};
      int ff;
      aw_delay = $urandom_range(0, 3);
      w_delay = $urandom_range(0, 3);
      bresp_err_idx = $urandom_range(0, 6);
      rbad = 4'($urandom_range(0, 15));
      ff = first_fail(bresp_err_idx, rbad);
      kick(cfg);
      wait_done(-1, 0);
      vectors++;
      if (write_errs(cfg) !== 0 || read_errs() !== 0) begin
        miscompares++; $display("FAIL rand%0d_xfer: %0d write / %0d read mismatches, want 0", it, write_errs(cfg), read_errs());
      end
      vectors++;
      if (error !== (ff >= 0) || (ff >= 0 && int'(err_index) != ff)) begin
        miscompares++; $display("FAIL rand%0d_error: error=%b err_index=%0d, want first failure %0d", it, error, err_index, ff);
      end
      if (aw_delay == 0 && w_delay == 0) begin
        vectors++;
        if (cyc !== zero_wait_cycles()) begin
          miscompares++; $display("FAIL rand%0d_latency: done at %0d, want %0d", it, cyc, zero_wait_cycles());
        end
      end
    end
    aw_delay = 0; w_delay = 0; bresp_err_idx = -1; rbad = '0;
  endtask
  initial begin
    test_reset();
    test_zero_wait();
    test_aw_delay();
    test_bresp_err();
    test_readback_err();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
